// File: rtl/vedic_dot_accumulator.sv
// Accumulates K qualified 32-bit products into one dot-product sum and presents it
// through a one-entry valid/ready output register. Optional: VEDIC_ACC_SATURATE_EN.
module vedic_dot_accumulator #(
  parameter  int K     = 8,
  parameter  int ACC_W = 40,
  localparam int CNT_W = $clog2(K)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      prod,
  input  logic             prod_valid,
  input  logic             clear,
  output logic [ACC_W-1:0] sum_out,
  output logic             sum_valid,
  input  logic             sum_ready,
  output logic [CNT_W-1:0] term_cnt,
  output logic             overrun,
  output logic             ovf
);

  // Output handshake: a sum is transferred when sum_valid && sum_ready at a rising
  // edge; sum_valid never drops without that transfer, and sum_out is stable while held.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(K - 1);

  out_state_e       state_q;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q;
  logic             overrun_q;

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W-1:0] add_res;
  logic             is_last;
  logic             complete;

  assign prod_ext = ACC_W'(prod);
  assign is_last  = (cnt_q == LAST_TERM);
  assign complete = prod_valid && !clear && is_last;

`ifdef VEDIC_ACC_SATURATE_EN
  logic [ACC_W:0] add_full;
  logic           add_ovf;
  logic           ovf_q;

  // One extra carry bit detects that the true sum no longer fits.
  assign add_full = {1'b0, acc_q} + {1'b0, prod_ext};
  assign add_ovf  = add_full[ACC_W];
  assign add_res  = add_ovf ? {ACC_W{1'b1}} : add_full[ACC_W-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ovf_q <= 1'b0;
    end else if (prod_valid && !clear && add_ovf) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf = ovf_q;
`else
  assign add_res = acc_q + prod_ext;
  assign ovf     = 1'b0;
`endif

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (clear) begin
      // A product arriving with clear starts the next dot product as its first term.
      acc_d = prod_valid ? prod_ext : '0;
      cnt_d = prod_valid ? CNT_W'(1) : '0;
    end else if (prod_valid) begin
      if (is_last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = add_res;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= EMPTY;
      sum_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (complete) begin
            sum_q   <= add_res;
            state_q <= FULL;
          end
        end
        FULL: begin
          if (complete) begin
            // A pop in the same cycle frees the slot; otherwise the new sum is lost.
            if (sum_ready) begin
              sum_q <= add_res;
            end else begin
              overrun_q <= 1'b1;
            end
          end else if (sum_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign sum_out   = sum_q;
  assign sum_valid = (state_q == FULL);
  assign term_cnt  = cnt_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_vedic_dot_accumulator.sv
// Self-checking bench for vedic_dot_accumulator: directed scenarios plus random
// traffic compared against a queue-based dot-product model.
module tb_vedic_dot_accumulator;

  localparam int K     = 8;
  localparam int ACC_W = 40;
  localparam int CNT_W = $clog2(K);
  localparam longint unsigned MAXV = (64'd1 << ACC_W) - 64'd1;

  logic             clk;
  logic             reset;
  logic [31:0]      prod;
  logic             prod_valid;
  logic             clear;
  logic [ACC_W-1:0] sum_out;
  logic             sum_valid;
  logic             sum_ready;
  logic [CNT_W-1:0] term_cnt;
  logic             overrun;
  logic             ovf;

  logic [31:0]      s_prod;
  logic             s_prod_valid;
  logic [32:0]      s_sum_out;
  logic             s_sum_valid;
  logic [1:0]       s_term_cnt;
  logic             s_overrun;
  logic             s_ovf;

  vedic_dot_accumulator #(.K(K), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .prod(prod), .prod_valid(prod_valid), .clear(clear),
    .sum_out(sum_out), .sum_valid(sum_valid), .sum_ready(sum_ready),
    .term_cnt(term_cnt), .overrun(overrun), .ovf(ovf)
  );

  vedic_dot_accumulator #(.K(3), .ACC_W(33)) dut_sat (
    .clk(clk), .reset(reset), .prod(s_prod), .prod_valid(s_prod_valid), .clear(1'b0),
    .sum_out(s_sum_out), .sum_valid(s_sum_valid), .sum_ready(1'b0),
    .term_cnt(s_term_cnt), .overrun(s_overrun), .ovf(s_ovf)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_vec  = 0;
  int n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: the pending terms of the current dot product plus the output slot
  longint unsigned terms[$];
  bit              m_full;
  longint unsigned m_sum;
  bit              m_overrun;
  bit              m_ovf;
  logic [63:0]     exp_q[$];

  function automatic longint unsigned terms_total();
    longint unsigned t = 0;
    foreach (terms[i]) t += terms[i];
    return t;
  endfunction

  function automatic longint unsigned limit(input longint unsigned t);
`ifdef VEDIC_ACC_SATURATE_EN
    return (t > MAXV) ? MAXV : t;
`else
    return t & MAXV;
`endif
  endfunction

  task automatic model_reset();
    terms.delete();
    m_full = 0; m_sum = 0; m_overrun = 0; m_ovf = 0;
  endtask

  task automatic model_clock(input bit pv, input longint unsigned p, input bit clr, input bit rdy);
    bit              comp;
    longint unsigned total;
    longint unsigned s;
    comp = pv && !clr && (terms.size() == K - 1);
    s = 0;
    if (clr) begin
      terms.delete();
      if (pv) terms.push_back(p);
    end else if (pv) begin
      terms.push_back(p);
      total = terms_total();
`ifdef VEDIC_ACC_SATURATE_EN
      if (total > MAXV) m_ovf = 1;
`endif
      if (comp) begin
        s = limit(total);
        terms.delete();
      end
    end
    if (comp) begin
      if (!m_full) begin
        m_sum = s; m_full = 1;
      end else if (rdy) begin
        m_sum = s;
      end else begin
        m_overrun = 1;
      end
    end else if (m_full && rdy) begin
      m_full = 0;
    end
  endtask

  task automatic check_all(input string tag);
    exp_q.push_back({63'd0, m_full});
    exp_q.push_back(m_sum);
    exp_q.push_back(64'(terms.size()));
    exp_q.push_back({63'd0, m_overrun});
    exp_q.push_back({63'd0, m_ovf});
    check_eq({tag, ".sum_valid"}, {63'd0, sum_valid}, exp_q.pop_front());
    check_eq({tag, ".sum_out"},   64'(sum_out),       exp_q.pop_front());
    check_eq({tag, ".term_cnt"},  64'(term_cnt),      exp_q.pop_front());
    check_eq({tag, ".overrun"},   {63'd0, overrun},   exp_q.pop_front());
    check_eq({tag, ".ovf"},       {63'd0, ovf},       exp_q.pop_front());
  endtask

  // driver: called at posedge+1, applies one cycle of inputs and checks afterwards
  task automatic step(input string tag, input bit pv, input logic [31:0] p,
                      input bit clr, input bit rdy);
    prod_valid = pv; prod = p; clear = clr; sum_ready = rdy;
    @(posedge clk);
    model_clock(pv, 64'(p), clr, rdy);
    #1;
    prod_valid = 1'b0; clear = 1'b0;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b0;
    prod = '0; prod_valid = 1'b0; clear = 1'b0; sum_ready = 1'b0;
    s_prod = '0; s_prod_valid = 1'b0;
    model_reset();
    #3;
    check_all("reset");
    #5 reset = 1'b1;
    @(posedge clk); #1;

    // wrap/saturation on the narrow instance
    s_prod_valid = 1'b1; s_prod = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1 s_prod_valid = 1'b0;
    check_eq("sat.sum_valid", {63'd0, s_sum_valid}, 64'd1);
`ifdef VEDIC_ACC_SATURATE_EN
    check_eq("sat.sum_out", 64'(s_sum_out), 64'h1_FFFF_FFFF);
    check_eq("sat.ovf", {63'd0, s_ovf}, 64'd1);
`else
    check_eq("sat.sum_out", 64'(s_sum_out), 64'h0_FFFF_FFFD);
    check_eq("sat.ovf", {63'd0, s_ovf}, 64'd0);
`endif
    check_eq("sat.term_cnt", 64'(s_term_cnt), 64'd0);

    // basic sum 1..8
    for (int i = 1; i <= K; i++) step("basic", 1'b1, 32'(i), 1'b0, 1'b1);
    check_eq("basic.sum36", 64'(sum_out), 64'd36);
    check_eq("basic.valid", {63'd0, sum_valid}, 64'd1);
    step("basic_pop", 1'b0, '0, 1'b0, 1'b1);

    // max operands
    for (int i = 0; i < K; i++) step("max", 1'b1, 32'hFFFE_0001, 1'b0, 1'b0);
    check_eq("max.sum", 64'(sum_out), 64'h7_FFF0_0008);
    step("max_pop", 1'b0, '0, 1'b0, 1'b1);

    // clear handling
    for (int i = 0; i < 3; i++) step("clr_acc", 1'b1, 32'd5, 1'b0, 1'b0);
    step("clr_alone", 1'b0, '0, 1'b1, 1'b0);
    check_eq("clr.term_cnt", 64'(term_cnt), 64'd0);
    check_eq("clr.no_valid", {63'd0, sum_valid}, 64'd0);
    step("clr_prod", 1'b1, 32'd7, 1'b1, 1'b0);
    for (int i = 0; i < K - 1; i++) step("clr_rest", 1'b1, 32'd1, 1'b0, 1'b0);
    check_eq("clr.sum14", 64'(sum_out), 64'd14);

    // simultaneous pop and completion while FULL (slot holds 14)
    for (int i = 0; i < K - 1; i++) step("popcomp", 1'b1, 32'd3, 1'b0, 1'b0);
    step("popcomp_last", 1'b1, 32'd3, 1'b0, 1'b1);
    check_eq("popcomp.sum24", 64'(sum_out), 64'd24);
    check_eq("popcomp.overrun", {63'd0, overrun}, 64'd0);
    step("popcomp_pop", 1'b0, '0, 1'b0, 1'b1);

    // backpressure: two dot products of ones with no pop
    for (int i = 0; i < 2 * K; i++) step("bp", 1'b1, 32'd1, 1'b0, 1'b0);
    check_eq("bp.sum8", 64'(sum_out), 64'd8);
    check_eq("bp.overrun", {63'd0, overrun}, 64'd1);
    step("bp_hold", 1'b0, '0, 1'b0, 1'b0);
    step("bp_pop", 1'b0, '0, 1'b0, 1'b1);
    check_eq("bp.valid_low", {63'd0, sum_valid}, 64'd0);

    // async reset mid dot product, with a held sum present
    for (int i = 0; i < K; i++) step("pre_rst_full", 1'b1, 32'd9, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step("pre_rst", 1'b1, 32'd2, 1'b0, 1'b0);
    check_eq("pre_rst.term_cnt", 64'(term_cnt), 64'd4);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    #2 reset = 1'b1;

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] p;
      case ($urandom_range(0, 3))
        0:       p = 32'hFFFF_FFFF;
        1:       p = 32'($urandom_range(0, 15));
        default: p = $urandom;
      endcase
      step("rand", ($urandom_range(0, 9) < 7), p, ($urandom_range(0, 15) == 0),
           $urandom_range(0, 1) == 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
